apply_iteration_controller: RTL and testbench

// Consumer end of the per-core iteration_end / active_v stream leaving the apply stage.

---
 rtl/apply_iteration_controller.sv | 152 +++++++++++++++
 tb/tb_apply_iteration_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/apply_iteration_controller.sv
// Collects per-core iteration_end, waits for the active-vertex stream to drain,
// then launches the next iteration or signals completion.
module apply_iteration_controller #(
    parameter int CORE_NUM        = 32,
    parameter int ITERATION_WIDTH = 16,
    parameter int MAX_ITERATION   = 64,
    parameter int DRAIN_CYCLES    = 4,
    parameter int UPD_CNT_WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CORE_NUM-1:0]        active_v_updated,
    input  logic [CORE_NUM-1:0]        active_v_valid,
    input  logic [CORE_NUM-1:0]        iteration_end,
    input  logic [CORE_NUM-1:0]        iteration_end_valid,
    output logic [ITERATION_WIDTH-1:0] iteration_id,
    output logic                       iteration_start,
    output logic                       iteration_running,
    output logic                       acc_done,
    output logic [UPD_CNT_WIDTH-1:0]   last_update_count
);

    localparam int PW = $clog2(CORE_NUM + 1);
    localparam int SW = UPD_CNT_WIDTH + PW;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [ITERATION_WIDTH-1:0] ILAST = ITERATION_WIDTH'(MAX_ITERATION - 1);
    localparam logic [UPD_CNT_WIDTH-1:0] UMAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DRAIN, S_DECIDE, S_NEXT, S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [ITERATION_WIDTH-1:0] id_q, id_d;
    logic                       start_q, start_d;
    logic                       run_q, run_d;
    logic                       done_q, done_d;
    logic [UPD_CNT_WIDTH-1:0]   last_q, last_d;
    logic [CORE_NUM-1:0]        end_seen_q, end_seen_d;
    logic [UPD_CNT_WIDTH-1:0]   upd_q, upd_d;
    logic [DW-1:0]              drain_q, drain_d;

    logic [CORE_NUM-1:0]      hit;
    logic [CORE_NUM-1:0]      end_now;
    logic [PW-1:0]            pc;
    logic [SW-1:0]            sum;
    logic [UPD_CNT_WIDTH-1:0] upd_add;

    always_comb begin
        hit = active_v_valid & active_v_updated;
        pc  = '0;
        for (int i = 0; i < CORE_NUM; i++) begin
            pc = pc + PW'(hit[i]);
        end
        // widened add so the saturation check cannot overflow
        sum     = SW'(upd_q) + SW'(pc);
        upd_add = (sum > SW'(UMAX)) ? UMAX : sum[UPD_CNT_WIDTH-1:0];
        end_now = end_seen_q | (iteration_end_valid & iteration_end);

        state_d    = state_q;
        id_d       = id_q;
        start_d    = 1'b0;
        done_d     = done_q;
        last_d     = last_q;
        end_seen_d = end_seen_q;
        upd_d      = upd_q;
        drain_d    = drain_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    id_d       = '0;
                    done_d     = 1'b0;
                    end_seen_d = '0;
                    upd_d      = '0;
                    start_d    = 1'b1;
                end
            end
            S_RUN: begin
                end_seen_d = end_now;
                upd_d      = upd_add;
                if (&end_now) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                upd_d = upd_add;
                if (|active_v_valid) begin
                    drain_d = '0;
                end else if (drain_q == DLAST) begin
                    state_d = S_DECIDE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DECIDE: begin
                last_d = upd_q;
                if (upd_q == '0 || id_q == ILAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                state_d    = S_RUN;
                id_d       = id_q + ITERATION_WIDTH'(1);
                end_seen_d = '0;
                upd_d      = '0;
                start_d    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        run_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            start_q    <= 1'b0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            last_q     <= '0;
            end_seen_q <= '0;
            upd_q      <= '0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            start_q    <= start_d;
            run_q      <= run_d;
            done_q     <= done_d;
            last_q     <= last_d;
            end_seen_q <= end_seen_d;
            upd_q      <= upd_d;
            drain_q    <= drain_d;
        end
    end

    assign iteration_id      = id_q;
    assign iteration_start   = start_q;
    assign iteration_running = run_q;
    assign acc_done          = done_q;
    assign last_update_count = last_q;

endmodule

// File: tb/tb_apply_iteration_controller.sv
// Directed bench for apply_iteration_controller (MAX_ITERATION=3,
// UPD_CNT_WIDTH=4 so the cap and saturation paths are reachable).
module tb_apply_iteration_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] avu = '0;
    logic [31:0] avv = '0;
    logic [31:0] ie = '0;
    logic [31:0] iev = '0;
    logic [15:0] id;
    logic        ist;
    logic        irun;
    logic        done;
    logic [3:0]  last;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apply_iteration_controller #(
        .CORE_NUM(32),
        .ITERATION_WIDTH(16),
        .MAX_ITERATION(3),
        .DRAIN_CYCLES(4),
        .UPD_CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .active_v_updated(avu),
        .active_v_valid(avv),
        .iteration_end(ie),
        .iteration_end_valid(iev),
        .iteration_id(id),
        .iteration_start(ist),
        .iteration_running(irun),
        .acc_done(done),
        .last_update_count(last)
    );

    typedef struct {
        logic        st;
        logic [31:0] ev;
        logic [31:0] e;
        logic [31:0] av;
        logic [31:0] au;
        logic        xs;
        logic        xr;
        logic        xd;
        logic [15:0] xi;
        logic [3:0]  xl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic [31:0] ev, logic [31:0] e,
                                logic [31:0] av, logic [31:0] au,
                                logic xs, logic xr, logic xd,
                                logic [15:0] xi, logic [3:0] xl);
        vec_t v;
        v.st = st; v.ev = ev; v.e = e; v.av = av; v.au = au;
        v.xs = xs; v.xr = xr; v.xd = xd; v.xi = xi; v.xl = xl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [31:0] ev, input logic [31:0] e,
                         input logic [31:0] av, input logic [31:0] au);
        start = s; iev = ev; ie = e; avv = av; avu = au;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic xs, input logic xr,
                        input logic xd, input logic [15:0] xi, input logic [3:0] xl);
        chk({tag, ".start"}, 32'(ist), 32'(xs));
        chk({tag, ".running"}, 32'(irun), 32'(xr));
        chk({tag, ".done"}, 32'(done), 32'(xd));
        chk({tag, ".id"}, 32'(id), 32'(xi));
        chk({tag, ".last"}, 32'(last), 32'(xl));
    endtask

    initial begin
        logic [31:0] ev, e, av, au;

        // start, then cores end one per cycle; core 31 shows valid-without-end early
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < 32; i++) begin
            ev = (32'd1 << i) | 32'h8000_0000;
            e  = 32'd1 << i;
            av = '0;
            au = '0;
            if (i == 0 || i == 3 || i == 7 || i == 12 || i == 20) begin
                av = 32'd1 << i;
                au = 32'd1 << i;
            end
            if (i == 5) av = 32'd1 << i;
            if (i == 6) au = 32'd1 << i;
            tbl.push_back(mk(i == 10, ev, e, av, au, 0, 1, 0, 0, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 5));

        // reset held while inputs toggle
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k[0]) drive(1, '1, '1, '1, '1);
            else drive(0, 0, 0, 0, 0);
            tick();
        end
        outs("t1_reset", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].st, tbl[n].ev, tbl[n].e, tbl[n].av, tbl[n].au);
            tick();
            outs($sformatf("vec%0d", n), tbl[n].xs, tbl[n].xr, tbl[n].xd,
                 tbl[n].xi, tbl[n].xl);
        end

        // drain restart: beat in second DRAIN cycle
        drive(0, '1, '1, 32'd1, 32'd1);
        tick();
        chk("t3_enter_drain", 32'(irun), 1);
        drive(0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 32'd2, 32'd2);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t3_quiet%0d", k), 32'(irun), 1);
        end
        tick();
        chk("t3_decide_running", 32'(irun), 0);
        tick();
        chk("t3_last", 32'(last), 2);
        chk("t3_nostart", 32'(ist), 0);
        tick();
        chk("t3_start", 32'(ist), 1);
        chk("t3_id", 32'(id), 2);

        // iteration 2 hits the cap; 20 updates saturate to 15
        drive(0, '1, '1, 32'h000F_FFFF, 32'h000F_FFFF);
        tick();
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        tick();
        chk("t5_decide_running", 32'(irun), 0);
        tick();
        outs("t5_done", 0, 0, 1, 2, 15);
        drive(0, '1, '1, '1, '1);
        for (int k = 0; k < 3; k++) begin
            tick();
            outs($sformatf("t5_hold%0d", k), 0, 0, 1, 2, 15);
        end
        drive(1, 0, 0, 0, 0);
        tick();
        outs("t5_restart", 1, 1, 0, 0, 15);
        drive(0, 0, 0, 0, 0);

        // convergence: no updates in iteration 0
        drive(0, '1, '1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        repeat (4) tick();
        tick();
        outs("t4_converged", 0, 0, 1, 0, 0);
        tick();
        chk("t4_no_start", 32'(ist), 0);

        // async reset mid-run
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk("t7_running", 32'(irun), 1);
        #2 rst = 1'b0;
        #1 outs("t7_async", 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("t7_post_start", 32'(ist), 0);
        chk("t7_post_run", 32'(irun), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
